// File: rtl/fp_normalize_round_if.sv
// -----------------------------------------------------------------------------
// fp_normalize_round_if
//   Beat interface between the multiplier, the normalize/round back end and the
//   result writeback register.
//   Input stream  : IN_VALID / IN_READY with payload MANT_IN[47:0], EXP_IN[9:0]
//                   (signed biased exponent), SIGN_IN, SPECIAL_IN[1:0], MODE_FP.
//   Output stream : OUT_VALID / OUT_READY with payload RESULT[31:0], FLAGS[4:0].
//   slave  modport : view of the fp_normalize_round block.
//   master modport : view of the surrounding environment that drives beats and
//                    consumes results.
// -----------------------------------------------------------------------------
interface fp_normalize_round_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [47:0] MANT_IN;
  logic [9:0]  EXP_IN;
  logic        SIGN_IN;
  logic [1:0]  SPECIAL_IN;
  logic        MODE_FP;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] RESULT;
  logic [4:0]  FLAGS;

  modport master (
    output IN_VALID, MANT_IN, EXP_IN, SIGN_IN, SPECIAL_IN, MODE_FP, OUT_READY,
    input  IN_READY, OUT_VALID, RESULT, FLAGS
  );

  modport slave (
    input  IN_VALID, MANT_IN, EXP_IN, SIGN_IN, SPECIAL_IN, MODE_FP, OUT_READY,
    output IN_READY, OUT_VALID, RESULT, FLAGS
  );
endinterface

// File: rtl/fp_normalize_round.sv
// -----------------------------------------------------------------------------
// fp_normalize_round
//   Back end of the FP multiply path. Takes the raw mantissa product, signed
//   biased exponent and sign, and produces a packed binary16/binary32 result
//   with status flags through a 3-stage valid/ready pipeline:
//     stage 1 normalize, stage 2 round-to-nearest-even, stage 3 pack.
//   Ports:
//     clk, rst_n   : rising-edge clock, asynchronous active-low reset
//     bus (slave)  : IN_* beat stream in, OUT_VALID/RESULT/FLAGS stream out
//                    FLAGS = {inexact, overflow, underflow, zero, inf/NaN}
//   Optional feature (macro FP_STICKY_FLAGS_EN):
//     FLAGS_CLR    : one-cycle pulse clearing the accumulated flags
//     STICKY_FLAGS : OR of FLAGS of every transferred result since reset/clear
// -----------------------------------------------------------------------------
module fp_normalize_round (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_normalize_round_if.slave   bus
`ifdef FP_STICKY_FLAGS_EN
  ,
  input  logic                  FLAGS_CLR,
  output logic [4:0]            STICKY_FLAGS
`endif
);

  typedef enum logic [1:0] {
    SP_NORMAL = 2'b00,
    SP_ZERO   = 2'b01,
    SP_INF    = 2'b10,
    SP_NAN    = 2'b11
  } special_e;

  // Ready chain: a stage loads when it is empty or its successor advances.
  logic w_s1_ready, w_s2_ready, w_s3_ready;
  logic r_s1_valid, r_s2_valid, r_s3_valid;

  assign w_s3_ready   = !r_s3_valid || bus.OUT_READY;
  assign w_s2_ready   = !r_s2_valid || w_s3_ready;
  assign w_s1_ready   = !r_s1_valid || w_s2_ready;
  assign bus.IN_READY = w_s1_ready;

  // ---------------- Stage 1: normalize ----------------
  // Half products live in [21:0]; upper bits are don't-care and masked here.
  logic [46:0] w_mant_in;
  logic        w_top;
  assign w_mant_in = bus.MODE_FP ? bus.MANT_IN[46:0] : {25'd0, bus.MANT_IN[21:0]};
  assign w_top     = bus.MODE_FP ? bus.MANT_IN[47]   : bus.MANT_IN[21];

  // Leading one is at bit 46 (single) / 20 (half) after this stage, so it is
  // implicit and not stored.
  logic [45:0] r_s1_mant;
  logic        r_s1_sticky;
  logic [9:0]  r_s1_exp;
  logic        r_s1_sign;
  special_e    r_s1_special;
  logic        r_s1_mode;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value; blocking here would let a beat
  // race through several stages in one clock.
  // NOTE: datapath registers are reset along with the valids; RESULT and FLAGS
  // must read zero out of reset and the cost is negligible at this width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_mant    <= '0;
      r_s1_sticky  <= 1'b0;
      r_s1_exp     <= '0;
      r_s1_sign    <= 1'b0;
      r_s1_special <= SP_NORMAL;
      r_s1_mode    <= 1'b0;
    end else if (w_s1_ready) begin
      r_s1_valid <= bus.IN_VALID;
      if (bus.IN_VALID) begin
        r_s1_mant    <= w_top ? w_mant_in[46:1] : w_mant_in[45:0];
        r_s1_sticky  <= w_top & w_mant_in[0];
        r_s1_exp     <= bus.EXP_IN + {9'd0, w_top};
        r_s1_sign    <= bus.SIGN_IN;
        r_s1_special <= special_e'(bus.SPECIAL_IN);
        r_s1_mode    <= bus.MODE_FP;
      end
    end
  end

  // ---------------- Stage 2: round to nearest even ----------------
  logic [22:0] w_frac;
  logic        w_guard, w_sticky, w_round_up, w_carry;
  logic [23:0] w_sum;
  logic [22:0] w_frac_rnd;
  logic [9:0]  w_exp_rnd;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    w_frac   = '0;
    w_guard  = 1'b0;
    w_sticky = r_s1_sticky;
    if (r_s1_mode) begin
      w_frac   = r_s1_mant[45:23];
      w_guard  = r_s1_mant[22];
      w_sticky = r_s1_sticky | (|r_s1_mant[21:0]);
    end else begin
      w_frac   = {13'd0, r_s1_mant[19:10]};
      w_guard  = r_s1_mant[9];
      w_sticky = r_s1_sticky | (|r_s1_mant[8:0]);
    end
    w_round_up = w_guard & (w_sticky | w_frac[0]);
    w_sum      = {1'b0, w_frac} + {23'd0, w_round_up};
    // Carry out of the fraction field means the mantissa rounded up to 2.0.
    w_carry    = r_s1_mode ? w_sum[23] : w_sum[10];
    w_frac_rnd = w_carry ? 23'd0 : w_sum[22:0];
    w_exp_rnd  = r_s1_exp + {9'd0, w_carry};
  end

  logic [22:0] r_s2_frac;
  logic [9:0]  r_s2_exp;
  logic        r_s2_sign;
  special_e    r_s2_special;
  logic        r_s2_mode;
  logic        r_s2_inexact;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid   <= 1'b0;
      r_s2_frac    <= '0;
      r_s2_exp     <= '0;
      r_s2_sign    <= 1'b0;
      r_s2_special <= SP_NORMAL;
      r_s2_mode    <= 1'b0;
      r_s2_inexact <= 1'b0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_frac    <= w_frac_rnd;
        r_s2_exp     <= w_exp_rnd;
        r_s2_sign    <= r_s1_sign;
        r_s2_special <= r_s1_special;
        r_s2_mode    <= r_s1_mode;
        r_s2_inexact <= w_guard | w_sticky;
      end
    end
  end

  // ---------------- Stage 3: pack ----------------
  logic signed [9:0] w_exp_s, w_exp_max;
  logic [31:0]       w_inf, w_zero, w_result;
  logic [4:0]        w_flags;

  assign w_exp_s   = r_s2_exp;
  assign w_exp_max = r_s2_mode ? 10'sd255 : 10'sd31;
  assign w_inf     = r_s2_mode ? {r_s2_sign, 8'hFF, 23'd0} : {16'd0, r_s2_sign, 5'h1F, 10'd0};
  assign w_zero    = r_s2_mode ? {r_s2_sign, 31'd0}        : {16'd0, r_s2_sign, 15'd0};

  always_comb begin
    w_result = '0;
    w_flags  = '0;
    if (r_s2_special == SP_NAN) begin
      w_result = r_s2_mode ? 32'h7FC0_0000 : 32'h0000_7E00;
      w_flags  = 5'b00001;
    end else if (r_s2_special == SP_INF) begin
      w_result = w_inf;
      w_flags  = 5'b00001;
    end else if (r_s2_special == SP_ZERO) begin
      w_result = w_zero;
      w_flags  = 5'b00010;
    end else if (w_exp_s >= w_exp_max) begin
      w_result = w_inf;
      w_flags  = 5'b11001;
    end else if (w_exp_s <= 10'sd0) begin
      w_result = w_zero;
      w_flags  = 5'b10110;
    end else begin
      w_result = r_s2_mode ? {r_s2_sign, r_s2_exp[7:0], r_s2_frac}
                           : {16'd0, r_s2_sign, r_s2_exp[4:0], r_s2_frac[9:0]};
      w_flags  = {r_s2_inexact, 4'b0000};
    end
  end

  logic [31:0] r_result;
  logic [4:0]  r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_valid <= 1'b0;
      r_result   <= '0;
      r_flags    <= '0;
    end else if (w_s3_ready) begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_result <= w_result;
        r_flags  <= w_flags;
      end
    end
  end

  assign bus.OUT_VALID = r_s3_valid;
  assign bus.RESULT    = r_result;
  assign bus.FLAGS     = r_flags;

`ifdef FP_STICKY_FLAGS_EN
  logic       w_xfer;
  logic [4:0] r_sticky_flags;
  assign w_xfer = r_s3_valid && bus.OUT_READY;

  // A transfer in the clear cycle still lands, so the clear only drops history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sticky_flags <= '0;
    else if (FLAGS_CLR)
      r_sticky_flags <= w_xfer ? r_flags : 5'd0;
    else if (w_xfer)
      r_sticky_flags <= r_sticky_flags | r_flags;
  end

  assign STICKY_FLAGS = r_sticky_flags;
`endif

endmodule

// File: tb/tb_fp_normalize_round.sv
// -----------------------------------------------------------------------------
// tb_fp_normalize_round
//   Self-checking bench for fp_normalize_round: a directed vector table, hand
//   sequences for backpressure and mid-stream reset, and randomized beats
//   checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fp_normalize_round;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_normalize_round_if bus ();

`ifdef FP_STICKY_FLAGS_EN
  logic       flags_clr = 1'b0;
  logic [4:0] sticky_flags;
`endif

  fp_normalize_round dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FP_STICKY_FLAGS_EN
    ,
    .FLAGS_CLR    (flags_clr),
    .STICKY_FLAGS (sticky_flags)
`endif
  );

  typedef struct {
    logic [47:0] mant;
    logic [9:0]  exp;
    logic        sign;
    logic [1:0]  special;
    logic        mode;
    logic [31:0] result;
    logic [4:0]  flags;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp_v);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: condition not met", name);
  endtask

  function automatic vec_t mk(input logic [47:0] m, input int e, input logic s,
                              input logic [1:0] sp, input logic md,
                              input logic [31:0] r, input logic [4:0] f);
    vec_t v;
    v.mant = m; v.exp = 10'(e); v.sign = s; v.special = sp; v.mode = md;
    v.result = r; v.flags = f;
    return v;
  endfunction

  // Reference model: treat the product as an integer, keep the fraction-width
  // bits below the leading one and round the discarded remainder against half
  // an ulp, ties to even.
  function automatic void ref_model(inout vec_t v);
    longint unsigned p, q, rem, halfv, one, r64;
    int top, fb, lead, drop, e, emax, sw;
    logic inexact;
    one = 1;
    sw  = v.mode ? 31 : 15;
    if (v.special == 2'b11) begin
      v.result = v.mode ? 32'h7FC0_0000 : 32'h0000_7E00; v.flags = 5'b00001; return;
    end
    top  = v.mode ? 47 : 21;
    fb   = v.mode ? 23 : 10;
    emax = v.mode ? 255 : 31;
    if (v.special == 2'b10) begin
      r64 = (longint'(v.sign) << sw) | (longint'(emax) << fb);
      v.result = r64[31:0]; v.flags = 5'b00001; return;
    end
    if (v.special == 2'b01) begin
      r64 = longint'(v.sign) << sw;
      v.result = r64[31:0]; v.flags = 5'b00010; return;
    end
    p    = v.mode ? longint'(v.mant) : longint'(v.mant & 48'h3F_FFFF);
    e    = int'($signed(v.exp));
    lead = p[top] ? top : top - 1;
    if (lead == top) e++;
    drop    = lead - fb;
    q       = p >> drop;
    rem     = p & ((one << drop) - 1);
    halfv   = one << (drop - 1);
    inexact = (rem != 0);
    if (rem > halfv || (rem == halfv && q[0])) q++;
    if (q == (one << (fb + 1))) begin q = q >> 1; e++; end
    if (e >= emax) begin
      r64 = (longint'(v.sign) << sw) | (longint'(emax) << fb);
      v.flags = 5'b11001;
    end else if (e <= 0) begin
      r64 = longint'(v.sign) << sw;
      v.flags = 5'b10110;
    end else begin
      r64 = (longint'(v.sign) << sw) | (longint'(e) << fb) | (q - (one << fb));
      v.flags = {inexact, 4'b0000};
    end
    v.result = r64[31:0];
  endfunction

  task automatic drive_beat(input vec_t v);
    bus.IN_VALID   = 1'b1;
    bus.MANT_IN    = v.mant;
    bus.EXP_IN     = v.exp;
    bus.SIGN_IN    = v.sign;
    bus.SPECIAL_IN = v.special;
    bus.MODE_FP    = v.mode;
  endtask

  // Streams vq through the DUT with random valid/ready duty cycles; expected
  // results queue up at acceptance and are compared in order at transfer.
  task automatic run_stream(input vec_t vq[$], input int ready_pct, input int valid_pct,
                            input string tag, output int cycles);
    vec_t        expq[$];
    vec_t        e;
    int          idx = 0;
    int          n_out = 0;
    logic        held = 1'b0;
    logic        acc_last = 1'b0;
    logic [31:0] h_res;
    logic [4:0]  h_flags;
    cycles = 0;
    while (!(idx == vq.size() && expq.size() == 0)) begin
      if (cycles >= 5000) begin fail_now({tag, "_timeout"}); break; end
      @(negedge clk);
      if (acc_last) bus.IN_VALID = 1'b0;
      if (!bus.IN_VALID && idx < vq.size() && $urandom_range(99) < valid_pct)
        drive_beat(vq[idx]);
      bus.OUT_READY = ($urandom_range(99) < ready_pct);
      #1;
      if (held)
        check({tag, "_hold"}, {27'd0, bus.OUT_VALID, bus.RESULT, bus.FLAGS},
              {27'd0, 1'b1, h_res, h_flags});
      held = bus.OUT_VALID && !bus.OUT_READY;
      if (held) begin h_res = bus.RESULT; h_flags = bus.FLAGS; end
      if (bus.OUT_VALID && bus.OUT_READY) begin
        if (expq.size() == 0) fail_now({tag, "_unexpected_out"});
        else begin
          e = expq.pop_front();
          check($sformatf("%s_out%0d", tag, n_out), {27'd0, bus.RESULT, bus.FLAGS},
                {27'd0, e.result, e.flags});
        end
        n_out++;
      end
      acc_last = bus.IN_VALID && bus.IN_READY;
      if (acc_last) begin expq.push_back(vq[idx]); idx++; end
      cycles++;
      @(posedge clk);
    end
    bus.IN_VALID = 1'b0;
  endtask

  initial begin
    vec_t tbl[$];
    vec_t rnd[$];
    vec_t v;
    int   cyc, acc, got, seen;
    longint unsigned a, b, p;

    rst_n = 1'b1;
    bus.IN_VALID = 1'b0; bus.MANT_IN = '0; bus.EXP_IN = '0; bus.SIGN_IN = 1'b0;
    bus.SPECIAL_IN = 2'b00; bus.MODE_FP = 1'b0; bus.OUT_READY = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_state", {26'd0, bus.OUT_VALID, bus.IN_READY, bus.RESULT, bus.FLAGS},
          {26'd0, 1'b0, 1'b1, 32'd0, 5'd0});
    @(posedge clk);

    // ---------------- directed table ----------------
    tbl.push_back(mk(48'h9000_0000_0000, 127, 0, 2'b00, 1, 32'h4010_0000, 5'b00000));
    tbl.push_back(mk(48'h0000_0010_0000,  15, 0, 2'b00, 0, 32'h0000_3C00, 5'b00000));
    tbl.push_back(mk(48'h4000_0080_0000, 127, 0, 2'b00, 1, 32'h3F80_0001, 5'b00000));
    tbl.push_back(mk(48'h4000_00C0_0000, 127, 0, 2'b00, 1, 32'h3F80_0002, 5'b10000));
    tbl.push_back(mk(48'h4000_0040_0000, 127, 0, 2'b00, 1, 32'h3F80_0000, 5'b10000));
    tbl.push_back(mk(48'h4000_0000_0000, 255, 0, 2'b00, 1, 32'h7F80_0000, 5'b11001));
    tbl.push_back(mk(48'h4000_0000_0000,   0, 1, 2'b00, 1, 32'h8000_0000, 5'b10110));
    tbl.push_back(mk(48'h4000_0000_0000, 127, 1, 2'b11, 1, 32'h7FC0_0000, 5'b00001));
    tbl.push_back(mk(48'h4000_0000_0000, 127, 1, 2'b10, 1, 32'hFF80_0000, 5'b00001));
    tbl.push_back(mk(48'h0000_0010_0000,  15, 1, 2'b11, 0, 32'h0000_7E00, 5'b00001));
    tbl.push_back(mk(48'h0000_0010_0000,  15, 0, 2'b10, 0, 32'h0000_7C00, 5'b00001));
    tbl.push_back(mk(48'h4000_0000_0000, 127, 1, 2'b01, 1, 32'h8000_0000, 5'b00010));
    tbl.push_back(mk(48'h0000_0010_0000,  15, 1, 2'b01, 0, 32'h0000_8000, 5'b00010));
    tbl.push_back(mk(48'h0000_0010_0000,  31, 0, 2'b00, 0, 32'h0000_7C00, 5'b11001));
    tbl.push_back(mk(48'h0000_0010_0000,   0, 1, 2'b00, 0, 32'h0000_8000, 5'b10110));
    tbl.push_back(mk(48'hFFFF_FFD0_0000,  15, 0, 2'b00, 0, 32'h0000_3C00, 5'b00000));
    tbl.push_back(mk(48'h0000_0024_0000,  15, 0, 2'b00, 0, 32'h0000_4080, 5'b00000));
    tbl.push_back(mk(48'h7FFF_FFC0_0000, 127, 0, 2'b00, 1, 32'h4000_0000, 5'b10000));
    tbl.push_back(mk(48'h7FFF_FFC0_0000, 254, 0, 2'b00, 1, 32'h7F80_0000, 5'b11001));
    tbl.push_back(mk(48'h4000_0000_0000,   1, 0, 2'b00, 1, 32'h0080_0000, 5'b00000));
    tbl.push_back(mk(48'h4000_0000_0000,-127, 0, 2'b00, 1, 32'h0000_0000, 5'b10110));
    tbl.push_back(mk(48'h8000_0000_0000, 381, 1, 2'b00, 1, 32'hFF80_0000, 5'b11001));

    // Full-rate stream: N beats need N cycles to enter plus 3 of latency.
    run_stream(tbl, 100, 100, "tbl", cyc);
    check("tbl_latency_throughput", 64'(cyc), 64'(tbl.size() + 3));

    // ---------------- backpressure: 5 offered, 3 accepted ----------------
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.OUT_READY = 1'b0;
      drive_beat(tbl[acc < 5 ? acc : 4]);
      #1;
      if (bus.IN_VALID && bus.IN_READY) acc++;
      @(posedge clk);
    end
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    #1;
    check("bp_accepted", 64'(acc), 64'd3);
    check("bp_in_ready_low", {62'd0, bus.IN_READY, bus.OUT_VALID}, {62'd0, 1'b0, 1'b1});
    check("bp_stalled_head", {27'd0, bus.RESULT, bus.FLAGS}, {27'd0, tbl[0].result, tbl[0].flags});
    @(posedge clk);
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.OUT_READY = 1'b1;
      #1;
      if (bus.OUT_VALID) begin
        if (got < 3)
          check($sformatf("bp_drain%0d", got), {27'd0, bus.RESULT, bus.FLAGS},
                {27'd0, tbl[got].result, tbl[got].flags});
        else fail_now("bp_extra_output");
        got++;
      end
      @(posedge clk);
    end
    check("bp_drain_count", 64'(got), 64'd3);

    // ---------------- reset mid-stream ----------------
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.OUT_READY = 1'b0;
      drive_beat(tbl[c]);
      @(posedge clk);
    end
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    #1;
    check("rst_pre_full", {63'd0, bus.OUT_VALID}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_clear", {26'd0, bus.OUT_VALID, bus.RESULT, bus.FLAGS}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.OUT_READY = 1'b1;
    #1;
    check("rst_in_ready", {63'd0, bus.IN_READY}, 64'd1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (bus.OUT_VALID) seen++;
      @(posedge clk);
    end
    check("rst_no_stale", 64'(seen), 64'd0);

    // ---------------- randomized beats vs. reference model ----------------
    for (int n = 0; n < 400; n++) begin
      v.mode = 1'($urandom_range(1));
      v.sign = 1'($urandom_range(1));
      v.special = ($urandom_range(7) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      if (v.mode) begin
        a = longint'($urandom_range(24'hFF_FFFF, 24'h80_0000));
        b = longint'($urandom_range(24'hFF_FFFF, 24'h80_0000));
        p = a * b;
        v.mant = p[47:0];
        v.exp  = 10'(int'($urandom_range(270)) - 8);
      end else begin
        a = longint'($urandom_range(2047, 1024));
        b = longint'($urandom_range(2047, 1024));
        p = a * b;
        v.mant = {26'($urandom), p[21:0]};
        v.exp  = 10'(int'($urandom_range(45)) - 8);
      end
      if ($urandom_range(15) == 0) v.exp = 10'(int'($urandom_range(508)) - 127);
      ref_model(v);
      rnd.push_back(v);
    end
    run_stream(rnd, 60, 70, "rnd", cyc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_normalize_round.md
# fp_normalize_round

Back end of the floating-point multiply path: consumes the raw (unnormalized, unrounded) mantissa product, biased exponent and sign from the multiplier and produces a packed IEEE-754 result plus status flags. Three-stage valid/ready pipeline (normalize, round-to-nearest-even, pack) supporting half (binary16) and single (binary32) precision, with per-stage backpressure. Sits between the multiplier and the result writeback register.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- IN_VALID  input  1  input beat valid
- IN_READY  output  1  block can accept a beat this cycle
- MANT_IN  input  48  mantissa product; single: full 24x24 product in [47:0]; half: 11x11 product in [21:0], [47:22] ignored
- EXP_IN  input  10  signed two's-complement biased exponent (EXP_A+EXP_B-bias)
- SIGN_IN  input  1  result sign
- SPECIAL_IN  input  2  00 normal, 01 zero, 10 infinity, 11 NaN
- MODE_FP  input  1  0 = half, 1 = single; sampled with the beat
- OUT_VALID  output  1  result valid
- OUT_READY  input  1  downstream accepts result
- RESULT  output  32  packed result; half in [15:0], [31:16] = 0
- FLAGS  output  5  [4] inexact, [3] overflow, [2] underflow, [1] zero, [0] infinity/NaN

## Operation
- Beat accepted when IN_VALID && IN_READY; MODE_FP, SPECIAL_IN travel with the beat.
- Stage 1 (normalize): product top bit P = 47 (single) / 21 (half). If bit P set: shift right 1, exponent +1, shifted-out bit ORed into sticky. Leading one now at P-1.
- Stage 2 (round): fraction = 23 (single) / 10 (half) bits below the leading one; guard = next bit; sticky = OR of all lower bits. Round up iff guard && (sticky || fraction LSB). Carry out of fraction: fraction = 0, exponent +1. inexact = guard || sticky.
- Stage 3 (pack), priority order:
  - SPECIAL_IN = 11: quiet NaN (0x7FC00000 / 0x7E00), sign 0, FLAGS = 00001.
  - SPECIAL_IN = 10: ±infinity, FLAGS = 00001.
  - SPECIAL_IN = 01: ±0, FLAGS = 00010.
  - exponent >= 255 (single) / 31 (half): ±infinity, FLAGS = {inexact=1, overflow=1, 0, 0, 1}.
  - exponent <= 0: flush to ±0 (sign kept), FLAGS = {1, 0, 1, 1, 0}.
  - otherwise {sign, exp[7:0]/[4:0], fraction}, FLAGS = {inexact, 0000}.
- Exponent arithmetic 10-bit signed throughout; no wrap for any legal input (-127..381).

## Timing
- Latency 3 cycles from accept to OUT_VALID with OUT_READY held high; throughput 1 beat/cycle.
- Each stage has a valid bit; a stage loads when empty or when its successor advances. IN_READY = !stage1_valid || stage1 advancing (combinational from OUT_READY through the chain).
- OUT_VALID, RESULT, FLAGS held stable while OUT_VALID && !OUT_READY.
- With OUT_READY low, exactly 3 beats accepted, then IN_READY = 0; no beat dropped or duplicated.
- Simultaneous accept and output in one cycle is legal and keeps the pipeline full.
- Reset (any time, including mid-stream): all stage valids 0, OUT_VALID 0, RESULT 0, FLAGS 0, IN_READY 1 after deassertion; in-flight beats discarded.

## Configuration
- FP_STICKY_FLAGS_EN defined: extra output STICKY_FLAGS[4:0] = OR of FLAGS over every result transferred (OUT_VALID && OUT_READY) since reset, plus input FLAGS_CLR (1 cycle pulse clears; a same-cycle transfer's flags still land after the clear).
- Undefined: neither port exists; no accumulation logic.

## Test plan
- Single 1.5x1.5: MANT_IN=0x900000000000, EXP_IN=127, sign 0 -> RESULT=0x40100000, FLAGS=00000, 3 cycles later.
- Half 1.0x1.0: MANT_IN=0x100000, EXP_IN=15, MODE_FP=0 -> RESULT=0x00003C00, FLAGS=00000.
- Rounding: MANT_IN=0x400000800000 / 0x400000C00000, EXP_IN=127 -> 0x3F800001 FLAGS=00000 / 0x3F800002 FLAGS=10000 (tie, odd LSB rounds up); 0x400000400000 -> 0x3F800000 FLAGS=10000 (tie to even).
- Range: MANT_IN=0x400000000000, EXP_IN=255 -> 0x7F800000 FLAGS=11001; EXP_IN=0, SIGN_IN=1 -> 0x80000000 FLAGS=10110.
- Specials: SPECIAL_IN=11 -> 0x7FC00000 FLAGS=00001; SPECIAL_IN=10, sign 1 -> 0xFF800000 FLAGS=00001.
- Backpressure/reset: OUT_READY=0, stream 5 beats -> 3 accepted, IN_READY low; release -> results in order, no loss; assert rst_n low mid-stream -> OUT_VALID=0 same cycle, no stale results after release.
